// File: rtl/join_64_bit.sv
// join_64_bit: assembles 64-bit words from pairs of 32-bit beats, zero-padding a short last
// beat, with flush of a held first beat and a running count of emitted words.
module join_64_bit #(
   parameter bit HIGH_FIRST = 1'b0,
   parameter int COUNT_W = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               flush,
   input  logic [31:0]        in_data,
   input  logic               in_valid,
   input  logic               in_last,
   output logic               in_ready,
   output logic [63:0]        out_data,
   output logic               out_valid,
   output logic               out_half,
   input  logic               out_ready,
   output logic               pending_low,
   output logic [COUNT_W-1:0] word_count
);
   typedef enum logic {EMPTY, HELD} state_t;
   state_t state, state_nx;
   logic [31:0] held, first, second;
   logic out_free, out_hs, in_hs, hold_beat, load;
   assign out_free = !out_valid | out_ready;
   assign out_hs = out_valid & out_ready;
   assign pending_low = state == HELD;
   always_comb begin
      in_ready = !flush & (pending_low ? out_free : (!in_last | out_free));
      in_hs = in_valid & in_ready;
      hold_beat = in_hs & !pending_low & !in_last;
      load = in_hs & !hold_beat;
      state_nx = flush ? EMPTY : hold_beat ? HELD : load ? EMPTY : state;
      first = pending_low ? held : in_data;
      second = pending_low ? in_data : 32'h0;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= EMPTY;
         held <= '0;
         out_data <= '0;
         out_valid <= 1'b0;
         out_half <= 1'b0;
         word_count <= '0;
      end else begin
         state <= state_nx;
         if (flush) held <= '0;
         else if (hold_beat) held <= in_data;
         if (load) begin
            out_data <= HIGH_FIRST ? {first, second} : {second, first};
            out_half <= !pending_low;
         end
         // a load in the same cycle as an output handshake replaces the word without a bubble
         out_valid <= load | (out_valid & !out_ready);
         word_count <= word_count + COUNT_W'(out_hs);
      end
   end
endmodule
